// File: rtl/phi2_bus_sequencer.sv
// Cycle-level bus sequencer for the 65C02: four fclk phases per phi2 period, CPU
// startup reset hold, RDY wait-state insertion and phi1/phi2 memory time-sharing.
module phi2_bus_sequencer #(
  parameter int unsigned RESET_HOLD  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clock_running,
  output logic [1:0] phase,
  output logic       phi2_rise_stb,
  output logic       phi2_fall_stb,
  output logic       cpu_resb,
  output logic       cpu_rdy,
  input  logic       cpu_addr_valid,
  input  logic       slow_sel,
  input  logic       dma_req,
  output logic       dma_gnt,
  output logic       mem_owner,
  output logic       mem_en
);

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned WAIT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [1:0]        phase_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              wait_pend, pend_nxt;
  logic              rise_nxt, fall_nxt, resb_nxt, rdy_nxt;
  logic              gnt_nxt, owner_nxt, en_nxt;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    hold_nxt  = hold_cnt;
    wait_nxt  = wait_cnt;
    pend_nxt  = wait_pend;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    resb_nxt  = cpu_resb;
    rdy_nxt   = cpu_rdy;
    gnt_nxt   = dma_gnt;
    owner_nxt = mem_owner;
    en_nxt    = mem_en;

    if (state == ST_IDLE || !clock_running) begin
      // Parked: phase frozen, CPU held in reset, no memory traffic.
      phase_nxt = 2'd0;
      hold_nxt  = '0;
      wait_nxt  = '0;
      pend_nxt  = 1'b0;
      resb_nxt  = 1'b0;
      rdy_nxt   = 1'b1;
      gnt_nxt   = 1'b0;
      owner_nxt = 1'b0;
      en_nxt    = 1'b0;
      state_nxt = (state == ST_IDLE && clock_running) ? ST_HOLD : ST_IDLE;
    end else if (state == ST_HOLD) begin
      phase_nxt = phase + 2'd1;
      gnt_nxt   = 1'b0;
      owner_nxt = 1'b0;
      en_nxt    = 1'b0;
      if (phase == 2'd3) begin
        hold_nxt = hold_cnt + HOLD_W'(1);
        if (({1'b0, hold_cnt} + (HOLD_W + 1)'(1)) >= (HOLD_W + 1)'(RESET_HOLD)) begin
          state_nxt = ST_RUN;
          resb_nxt  = 1'b1;
        end
      end
    end else begin
      phase_nxt = phase + 2'd1;
      resb_nxt  = 1'b1;
      case (phase)
        2'd1: begin
          gnt_nxt   = 1'b0;
          owner_nxt = 1'b0;
          en_nxt    = cpu_addr_valid;
        end
        2'd2: begin
          en_nxt = cpu_addr_valid;
          if (WAIT_STATES != 0 && wait_cnt == '0 && cpu_addr_valid && slow_sel)
            pend_nxt = 1'b1;
        end
        2'd3: begin
          // phi1 slot of the next cycle goes to DMA if it asked now.
          gnt_nxt   = dma_req;
          owner_nxt = dma_req;
          en_nxt    = dma_req;
          if (wait_pend) begin
            pend_nxt = 1'b0;
            rdy_nxt  = 1'b0;
            wait_nxt = WAIT_W'(WAIT_STATES);
          end else if (wait_cnt != '0) begin
            wait_nxt = wait_cnt - WAIT_W'(1);
            if (wait_cnt == WAIT_W'(1))
              rdy_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (state_nxt != ST_IDLE) begin
      rise_nxt = (phase_nxt == 2'd2);
      fall_nxt = (phase_nxt == 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      phase         <= 2'd0;
      hold_cnt      <= '0;
      wait_cnt      <= '0;
      wait_pend     <= 1'b0;
      phi2_rise_stb <= 1'b0;
      phi2_fall_stb <= 1'b0;
      cpu_resb      <= 1'b0;
      cpu_rdy       <= 1'b1;
      dma_gnt       <= 1'b0;
      mem_owner     <= 1'b0;
      mem_en        <= 1'b0;
    end else begin
      state         <= state_nxt;
      phase         <= phase_nxt;
      hold_cnt      <= hold_nxt;
      wait_cnt      <= wait_nxt;
      wait_pend     <= pend_nxt;
      phi2_rise_stb <= rise_nxt;
      phi2_fall_stb <= fall_nxt;
      cpu_resb      <= resb_nxt;
      cpu_rdy       <= rdy_nxt;
      dma_gnt       <= gnt_nxt;
      mem_owner     <= owner_nxt;
      mem_en        <= en_nxt;
    end
  end

endmodule

// File: tb/tb_phi2_bus_sequencer.sv
// Directed bench for phi2_bus_sequencer: table-driven arbitration vectors plus
// hand-written sequences for startup hold, wait states, clock loss and reset.
module tb_phi2_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset, clock_running, cpu_addr_valid, slow_sel, dma_req;
  logic [1:0] phase, phase1;
  logic       rise, fall, resb, rdy, gnt, owner, en;
  logic       rise1, fall1, resb1, rdy1, gnt1, owner1, en1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phi2_bus_sequencer #(.RESET_HOLD(8), .WAIT_STATES(2)) u0 (
    .clk(clk), .reset(reset), .clock_running(clock_running), .phase(phase),
    .phi2_rise_stb(rise), .phi2_fall_stb(fall), .cpu_resb(resb), .cpu_rdy(rdy),
    .cpu_addr_valid(cpu_addr_valid), .slow_sel(slow_sel), .dma_req(dma_req),
    .dma_gnt(gnt), .mem_owner(owner), .mem_en(en));

  phi2_bus_sequencer #(.RESET_HOLD(1), .WAIT_STATES(0)) u1 (
    .clk(clk), .reset(reset), .clock_running(clock_running), .phase(phase1),
    .phi2_rise_stb(rise1), .phi2_fall_stb(fall1), .cpu_resb(resb1), .cpu_rdy(rdy1),
    .cpu_addr_valid(cpu_addr_valid), .slow_sel(slow_sel), .dma_req(dma_req),
    .dma_gnt(gnt1), .mem_owner(owner1), .mem_en(en1));

  typedef struct {
    logic       dma, cav, slow;
    logic [1:0] ph;
    logic       g, o, e, r;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Startup hold for u0 (RESET_HOLD=8): call at the sample point where clock_running rose.
  task automatic run_hold();
    int bad = 0, rises = 0, u1_low = 0;
    step();
    for (int i = 0; i < 32; i++) begin
      if (phase != 2'(i % 4) || resb != 1'b0 || en != 1'b0 || gnt != 1'b0) bad++;
      rises += int'(rise);
      if (!resb1) u1_low++;
      step();
    end
    chk("hold_seq_violations", bad, 0);
    chk("hold_rise_count", rises, 8);
    chk("hold_u1_resb_low", u1_low, 4);
    chk("run_resb", resb, 1);
    chk("run_phase", phase, 0);
  endtask

  vec_t arb[16];

  initial begin
    arb[0]  = '{1,1,0, 2'd1, 0,0,0,1};
    arb[1]  = '{1,1,0, 2'd2, 0,0,1,1};
    arb[2]  = '{1,1,0, 2'd3, 0,0,1,1};
    arb[3]  = '{1,1,0, 2'd0, 1,1,1,1};
    arb[4]  = '{1,1,0, 2'd1, 1,1,1,1};
    arb[5]  = '{1,1,0, 2'd2, 0,0,1,1};
    arb[6]  = '{1,1,0, 2'd3, 0,0,1,1};
    arb[7]  = '{1,1,0, 2'd0, 1,1,1,1};
    arb[8]  = '{0,1,0, 2'd1, 1,1,1,1};
    arb[9]  = '{0,1,0, 2'd2, 0,0,1,1};
    arb[10] = '{0,0,0, 2'd3, 0,0,0,1};
    arb[11] = '{0,1,0, 2'd0, 0,0,0,1};
    arb[12] = '{0,1,0, 2'd1, 0,0,0,1};
    arb[13] = '{0,1,0, 2'd2, 0,0,1,1};
    arb[14] = '{0,1,0, 2'd3, 0,0,1,1};
    arb[15] = '{0,1,0, 2'd0, 0,0,0,1};

    reset = 1'b1; clock_running = 1'b0;
    cpu_addr_valid = 1'b0; slow_sel = 1'b0; dma_req = 1'b0;
    repeat (3) step();
    chk("rst_phase", phase, 0);
    chk("rst_resb", resb, 0);
    chk("rst_rdy", rdy, 1);
    chk("rst_strobes", {rise, fall}, 0);
    chk("rst_bus", {gnt, owner, en}, 0);
    chk("rst_u1_rdy", rdy1, 1);

    // Startup hold
    reset = 1'b0; clock_running = 1'b1;
    run_hold();

    // Arbitration vectors
    for (int i = 0; i < 16; i++) begin
      dma_req = arb[i].dma; cpu_addr_valid = arb[i].cav; slow_sel = arb[i].slow;
      step();
      chk($sformatf("arb%0d_phase", i), phase, arb[i].ph);
      chk($sformatf("arb%0d_gnt", i), gnt, arb[i].g);
      chk($sformatf("arb%0d_owner", i), owner, arb[i].o);
      chk($sformatf("arb%0d_en", i), en, arb[i].e);
      chk($sformatf("arb%0d_rdy", i), rdy, arb[i].r);
    end

    // Wait states: advance to phase 2, then hold a slow access for 20 clk
    dma_req = 1'b0; cpu_addr_valid = 1'b1; slow_sel = 1'b0;
    step(); step();
    chk("ws_start_phase", phase, 2);
    slow_sel = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("ws_rdy_k%0d", k), rdy,
          ((k >= 2 && k <= 9) || (k >= 14)) ? 0 : 1);
      chk($sformatf("ws0_rdy_k%0d", k), rdy1, 1);
    end

    // Clock loss mid-wait at phase 1, with a DMA grant active
    dma_req = 1'b1;
    repeat (7) step();
    chk("loss_pre_phase", phase, 1);
    chk("loss_pre_rdy", rdy, 0);
    chk("loss_pre_gnt", gnt, 1);
    clock_running = 1'b0;
    step();
    chk("loss_phase", phase, 0);
    chk("loss_resb", resb, 0);
    chk("loss_rdy", rdy, 1);
    chk("loss_bus", {gnt, owner, en}, 0);
    chk("loss_strobes", {rise, fall}, 0);
    clock_running = 1'b1;
    run_hold();

    // Synchronous reset pulse at phase 3 with DMA requesting
    repeat (3) step();
    chk("rst2_pre_phase", phase, 3);
    reset = 1'b1;
    step();
    chk("rst2_phase", phase, 0);
    chk("rst2_resb", resb, 0);
    chk("rst2_rdy", rdy, 1);
    chk("rst2_bus", {gnt, owner, en}, 0);
    chk("rst2_strobes", {rise, fall}, 0);
    reset = 1'b0; clock_running = 1'b0;
    step(); step();
    chk("idle_phase", phase, 0);
    chk("idle_fall", fall, 0);
    clock_running = 1'b1;
    step();
    chk("rehold_fall", fall, 1);
    chk("rehold_resb", resb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phi2_bus_sequencer.md
Name: phi2_bus_sequencer

Overview:
- Cycle-level bus controller for the 65C02 core. It runs on the 4x-phi2 fast clock and splits each phi2 period into four phases.
- It sequences the CPU's startup reset after the clocking unit reports clock_running, and inserts RDY wait states for slow devices.
- It time-shares the memory port: the DMA/video requester gets the phi1 half of each cycle, the CPU gets the phi2 half.

Parameters:
- RESET_HOLD, 8, number of full phi2 cycles cpu_resb is held low after clock_running rises (legal range 1..255).
- WAIT_STATES, 2, number of phi2 cycles cpu_rdy is held low per slow access (0 disables wait insertion; legal range 0..15).

Ports:
- clk, input, 1, fast clock (fclk, 4x phi2); all logic is on its rising edge.
- reset, input, 1, synchronous, active-high.
- clock_running, input, 1, clock-stable flag from the clocking unit.
- phase, output, 2, current phase; 0,1 = phi1 (phi2 low), 2,3 = phi2 high.
- phi2_rise_stb, output, 1, one-clk pulse during phase 2.
- phi2_fall_stb, output, 1, one-clk pulse during phase 0.
- cpu_resb, output, 1, active-low CPU reset.
- cpu_rdy, output, 1, CPU RDY.
- cpu_addr_valid, input, 1, CPU presents a valid bus cycle.
- slow_sel, input, 1, current CPU access targets a slow device.
- dma_req, input, 1, secondary requester wants a memory slot.
- dma_gnt, output, 1, DMA owns the memory port this phase.
- mem_owner, output, 1, 0 = CPU, 1 = DMA.
- mem_en, output, 1, memory port access enable.

Behaviour:
- Reset values: phase=0; phi2_rise_stb=0; phi2_fall_stb=0; cpu_resb=0; cpu_rdy=1; dma_gnt=0; mem_owner=0; mem_en=0; FSM=IDLE; all counters 0. Every output is registered.
- FSM states: IDLE, HOLD, RUN.
  - IDLE: phase frozen at 0; strobes 0; cpu_resb=0. Goes to HOLD on the first clk with clock_running=1.
  - HOLD: phase counter runs 0,1,2,3 and wraps. The hold counter increments when phase goes 3->0. Goes to RUN when the counter reaches RESET_HOLD, at that 3->0 wrap. cpu_resb rises on the same edge the FSM enters RUN, so it is aligned to phase 0.
  - RUN: cpu_resb=1.
  - From HOLD or RUN, clock_running=0 sampled high-to-low goes to IDLE next clk. On that transition: phase->0, cpu_resb->0, cpu_rdy->1, dma_gnt->0, mem_en->0, wait counter cleared. A later clock_running=1 restarts the full HOLD count.
- Strobes are active only in HOLD and RUN.
- Arbitration (RUN only):
  - dma_req is sampled at phase 3.
  - If it is high, dma_gnt=1, mem_owner=1 and mem_en=1 for phases 0 and 1 of the next phi2 cycle. Otherwise those phases are idle (mem_en=0).
  - In phases 2 and 3: dma_gnt=0, mem_owner=0, and mem_en=cpu_addr_valid.
  - The CPU always wins phi2-high, so there is no contention. dma_req dropping mid-grant does not shorten the grant.
- Wait states (RUN, WAIT_STATES>0):
  - cpu_addr_valid & slow_sel are sampled at phase 2 while the wait counter is 0.
  - If both are high, cpu_rdy goes to 0 at the next phase 0 and the wait counter loads WAIT_STATES.
  - The counter decrements at each 3->0 wrap. cpu_rdy returns to 1 at the phase-0 edge where the counter reaches 0.
  - slow_sel is ignored while the counter is nonzero (a repeated access is not re-stretched).
  - The next phase-2 sample after release may start a new stretch.
  - DMA grants continue normally during waits.
- HOLD state: mem_en=0 and dma_gnt=0 (no traffic before the CPU is out of reset).
- Synchronous reset asserted in any state and any phase forces all reset values on the next edge. It overrides clock_running.

Test Plan:
1. reset=1 for 3 clk, then clock_running=1 with RESET_HOLD=8 → HOLD entered after 1 clk. phase cycles 0-3. cpu_resb stays 0 for 32 clk, then rises at phase 0. phi2_rise_stb pulses exactly 8 times during HOLD.
2. RUN, dma_req=1 continuously, cpu_addr_valid=1 → per 4-clk cycle mem_owner/dma_gnt = 1,1,0,0 and mem_en = 1,1,1,1. With dma_req=0 → dma_gnt always 0 and mem_en = 0,0,1,1.
3. RUN, WAIT_STATES=2, slow_sel=1 and cpu_addr_valid=1 held for 20 clk starting at phase 2 → cpu_rdy low for exactly 8 clk starting at the next phase 0. slow_sel is ignored during the stretch. A second stretch begins at the phase 0 after the next phase-2 sample.
4. WAIT_STATES=0, slow_sel=1 → cpu_rdy never drops.
5. clock_running falls mid-wait in RUN at phase 1 → next clk: phase=0, cpu_resb=0, cpu_rdy=1, mem_en=0. Raising clock_running again gives a full 8-cycle HOLD.
6. reset pulsed for 1 clk at phase 3 in RUN with dma_req=1 → next clk all outputs at reset values, dma_gnt=0, FSM=IDLE.
